// File: rtl/ixc_skid_stage_84_if.sv
// Valid/ready handshake bundle for the 84-bit skid stage: producer side plus consumer side.
interface ixc_skid_stage_84_if #(
  parameter int WIDTH = 84
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  // slave is the skid stage itself; master is whoever drives its input and consumes its output
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/ixc_skid_stage_84.sv
// Two-entry registered skid buffer: main reg drives the output, skid reg absorbs one overflow word.
// Ready/valid are flops, so no combinational path exists from out_ready to in_ready.
module ixc_skid_stage_84 #(
  parameter int WIDTH = 84,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  ixc_skid_stage_84_if.slave     bus,
  output logic [1:0]             occupancy,
  output logic [CNT_W-1:0]       stall_cnt
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t           state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_xfer;
  logic             out_xfer;

  assign in_xfer       = bus.in_valid & bus.in_ready;
  assign out_xfer      = bus.out_valid & bus.out_ready;
  assign bus.out_data  = main_q;
  assign occupancy     = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= EMPTY;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      main_q        <= '0;
      skid_q        <= '0;
      stall_cnt     <= '0;
    end else if (flush) begin
      // Any word offered this cycle is dropped along with the buffered ones
      state         <= EMPTY;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      stall_cnt     <= '0;
    end else begin
      if (bus.out_valid && !bus.out_ready && stall_cnt != {CNT_W{1'b1}})
        stall_cnt <= stall_cnt + 1'b1;
      case (state)
        EMPTY: if (in_xfer) begin
          main_q        <= bus.in_data;
          state         <= ONE;
          bus.out_valid <= 1'b1;
        end
        ONE: case ({in_xfer, out_xfer})
          2'b10: begin
            skid_q       <= bus.in_data;
            state        <= TWO;
            bus.in_ready <= 1'b0;
          end
          2'b01: begin
            state         <= EMPTY;
            bus.out_valid <= 1'b0;
          end
          2'b11: main_q <= bus.in_data;
          default: ;
        endcase
        TWO: if (out_xfer) begin
          main_q       <= skid_q;
          state        <= ONE;
          bus.in_ready <= 1'b1;
        end
        default: begin
          state         <= EMPTY;
          bus.in_ready  <= 1'b1;
          bus.out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ixc_skid_stage_84.sv
// Directed plus random stimulus against a queue-based model of the skid stage.
module tb_ixc_skid_stage_84;
  localparam int W     = 84;
  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] stall_cnt;

  ixc_skid_stage_84_if #(.WIDTH(W)) bus ();

  ixc_skid_stage_84 #(.WIDTH(W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .bus       (bus),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] m_q[$];
  int           m_stall = 0;
  bit           m_rst_seen = 1'b0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_word();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[W-1:0];
  endfunction

  // One clock: apply inputs, advance the model on the edge, compare just after it
  task automatic step(input bit r, input bit f, input bit v, input logic [W-1:0] d, input bit o);
    bit acc, pop;
    rst_n = !r; flush = f; bus.in_valid = v; bus.in_data = d; bus.out_ready = o;
    @(posedge clk);
    acc = v && (m_q.size() < 2);
    pop = (m_q.size() > 0) && o;
    if (r) begin
      m_q.delete(); m_stall = 0; m_rst_seen = 1'b1;
    end else if (f) begin
      m_q.delete(); m_stall = 0; m_rst_seen = 1'b0;
    end else begin
      if (m_q.size() > 0 && !o && m_stall < SAT) m_stall++;
      if (pop) void'(m_q.pop_front());
      if (acc) m_q.push_back(d);
      m_rst_seen = 1'b0;
    end
    #1;
    chk("out_valid", W'(bus.out_valid), W'(m_q.size() > 0));
    chk("in_ready",  W'(bus.in_ready),  W'(m_q.size() < 2));
    chk("occupancy", W'(occupancy),     W'(m_q.size()));
    chk("stall_cnt", W'(stall_cnt),     W'(m_stall));
    if (m_q.size() > 0) chk("out_data", bus.out_data, m_q[0]);
    else if (m_rst_seen) chk("out_data_rst", bus.out_data, '0);
  endtask

  initial begin
    logic [W-1:0] a, b, c, hold;
    rst_n = 1'b0; flush = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;

    // 1: reset then a single word
    step(1, 0, 0, '0, 0);
    step(1, 0, 0, '0, 0);
    step(0, 0, 1, W'(1), 1);
    chk("t1_data", bus.out_data, W'(1));
    chk("t1_occ", W'(occupancy), W'(1));

    // 2: streaming 0..15 with both sides ready
    step(0, 0, 0, '0, 1);
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 1, W'(i), 1);
      chk("t2_data", bus.out_data, W'(i));
      chk("t2_ready", W'(bus.in_ready), W'(1));
    end
    step(0, 0, 0, '0, 1);
    chk("t2_stall", W'(stall_cnt), '0);

    // 3: back-pressure fills both entries, then drains in order
    a = rnd_word(); b = rnd_word();
    step(0, 0, 1, a, 0);
    step(0, 0, 1, b, 0);
    chk("t3_occ", W'(occupancy), W'(2));
    chk("t3_ready", W'(bus.in_ready), '0);
    hold = bus.out_data;
    step(0, 0, 1, rnd_word(), 0);
    chk("t3_stable", bus.out_data, hold);
    chk("t3_a", bus.out_data, a);
    step(0, 0, 0, '0, 1);
    chk("t3_b", bus.out_data, b);
    step(0, 0, 0, '0, 1);

    // 4: flush with both entries full while C is offered
    step(0, 0, 1, a, 0);
    step(0, 0, 1, b, 0);
    c = rnd_word();
    step(0, 1, 1, c, 0);
    chk("t4_occ", W'(occupancy), '0);
    chk("t4_valid", W'(bus.out_valid), '0);
    chk("t4_stall", W'(stall_cnt), '0);
    step(0, 0, 0, '0, 1);
    chk("t4_no_c", W'(bus.out_valid), '0);

    // 5: stall counter saturates
    step(0, 0, 1, a, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, '0, 0);
    chk("t5_sat", W'(stall_cnt), W'(SAT));
    step(0, 0, 0, '0, 0);
    chk("t5_hold", W'(stall_cnt), W'(SAT));

    // 6: reset while full
    step(0, 0, 1, b, 0);
    chk("t6_full", W'(occupancy), W'(2));
    step(1, 0, 1, c, 0);
    chk("t6_valid", W'(bus.out_valid), '0);
    chk("t6_data", bus.out_data, '0);
    step(0, 0, 0, '0, 0);
    chk("t6_ready", W'(bus.in_ready), W'(1));

    // Random traffic with occasional flush and reset
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 59) == 0),
           ($urandom_range(0, 3) != 0), rnd_word(), ($urandom_range(0, 2) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
